// File: rtl/omem_write_queue_if.sv
// Write-queue bus bundle: the core-side push port, the OMEM-side write port,
// and the flush/status signals.
interface omem_write_queue_if #(
  parameter int ROW_WIDTH = 96,
  parameter int CNT_W     = 4
);
  logic                 iWriteEnable;
  logic [ROW_WIDTH-1:0] iWriteAddress;
  logic [ROW_WIDTH-1:0] iWriteData;
  logic                 oAccept;
  logic                 oOMEM_WriteEnable;
  logic [ROW_WIDTH-1:0] oOMEM_WriteAddress;
  logic [ROW_WIDTH-1:0] oOMEM_WriteData;
  logic                 iOMEM_Ready;
  logic                 iFlush;
  logic                 oFlushDone;
  logic                 oFull;
  logic                 oEmpty;
  logic [CNT_W-1:0]     oCount;
  logic                 oOverflow;

  // The queue itself.
  modport slave (
    input  iWriteEnable, iWriteAddress, iWriteData, iOMEM_Ready, iFlush,
    output oAccept, oOMEM_WriteEnable, oOMEM_WriteAddress, oOMEM_WriteData,
           oFlushDone, oFull, oEmpty, oCount, oOverflow
  );

  // Whoever drives pushes and consumes the OMEM writes.
  modport master (
    output iWriteEnable, iWriteAddress, iWriteData, iOMEM_Ready, iFlush,
    input  oAccept, oOMEM_WriteEnable, oOMEM_WriteAddress, oOMEM_WriteData,
           oFlushDone, oFull, oEmpty, oCount, oOverflow
  );
endinterface

// File: rtl/omem_write_queue.sv
// Elastic write buffer in front of the OMEM write port. Entries leave one per
// ready cycle, in push order, with no same-cycle bypass. A flush request
// produces a one-cycle done pulse once the queue has drained.
module omem_write_queue #(
  parameter int ROW_WIDTH = 96,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  omem_write_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FLUSHING, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [ROW_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [ROW_WIDTH-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_ovf;
  logic                 w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = !w_empty && bus.iOMEM_Ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push  = bus.iWriteEnable && (!w_full || w_pop);

  assign bus.oAccept            = w_push;
  assign bus.oOMEM_WriteEnable  = w_pop;
  assign bus.oOMEM_WriteAddress = w_empty ? '0 : r_addr_mem[r_rptr];
  assign bus.oOMEM_WriteData    = w_empty ? '0 : r_data_mem[r_rptr];
  assign bus.oFull              = w_full;
  assign bus.oEmpty             = w_empty;
  assign bus.oCount             = r_count;
  assign bus.oOverflow          = r_ovf;
  assign bus.oFlushDone         = (r_state == S_DONE);

  // Occupancy after this cycle; the flush FSM keys off it.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage; stale contents are harmless since the outputs are masked when empty.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= bus.iWriteAddress;
      r_data_mem[r_wptr] <= bus.iWriteData;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      if (bus.iWriteEnable && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Flush state register.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Flush sequencing: wait for the queue to empty, pulse done, and let a new
  // request arriving during the pulse restart the wait straight away.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.iFlush) w_state_nxt = S_FLUSHING;
      S_FLUSHING: if (w_count_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = bus.iFlush ? S_FLUSHING : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_omem_write_queue.sv
// Scoreboard bench for omem_write_queue: accepted pushes are queued as the
// expected write stream, a monitor consumes it as OMEM writes appear, and an
// occupancy/flush model checks the status outputs every cycle.
module tb_omem_write_queue;
  localparam int RW    = 96;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [RW-1:0] d;
  } ent_t;

  logic Clock = 1'b0;
  logic Reset;
  bit   started = 1'b0;

  omem_write_queue_if #(.ROW_WIDTH(RW), .CNT_W(CNT_W)) bus();

  omem_write_queue #(.ROW_WIDTH(RW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  ent_t sb_q[$];
  int   m_count = 0;
  bit   m_ovf = 1'b0, m_flushing = 1'b0, m_done = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, overflow and flush progress, advanced on each edge.
  always @(posedge Clock) begin
    bit pop, push;
    int nxt;
    if (Reset) begin
      m_count = 0; m_ovf = 0; m_flushing = 0; m_done = 0;
      sb_q.delete();
    end else begin
      pop  = (m_count != 0) && bus.iOMEM_Ready;
      push = bus.iWriteEnable && ((m_count < DEPTH) || pop);
      if (bus.iWriteEnable && m_count == DEPTH && !pop) m_ovf = 1;
      if (push) sb_q.push_back({bus.iWriteAddress, bus.iWriteData});
      nxt = m_count + int'(push) - int'(pop);
      m_done     = m_flushing && (nxt == 0);
      m_flushing = m_flushing ? (nxt != 0) : bus.iFlush;
      m_count    = nxt;
    end
  end

  // Status/handshake checks against the model.
  always @(negedge Clock) begin
    bit e_pop, e_acc;
    if (started) begin
      e_pop = (m_count != 0) && bus.iOMEM_Ready;
      e_acc = bus.iWriteEnable && ((m_count < DEPTH) || e_pop);
      chk("accept",    RW'(bus.oAccept),           RW'(e_acc));
      chk("write_en",  RW'(bus.oOMEM_WriteEnable), RW'(e_pop));
      chk("count",     RW'(bus.oCount),            RW'(m_count));
      chk("empty",     RW'(bus.oEmpty),            RW'(m_count == 0));
      chk("full",      RW'(bus.oFull),             RW'(m_count == DEPTH));
      chk("overflow",  RW'(bus.oOverflow),         RW'(m_ovf));
      chk("flushdone", RW'(bus.oFlushDone),        RW'(m_done));
    end
  end

  // Monitor: head contents and the write stream against the scoreboard.
  always @(negedge Clock) begin
    if (started) begin
      if (bus.oEmpty) begin
        chk("empty_addr", bus.oOMEM_WriteAddress, '0);
        chk("empty_data", bus.oOMEM_WriteData, '0);
      end else if (sb_q.size() == 0) begin
        chk("head_no_entry", RW'(sb_q.size()), RW'(1));
      end else begin
        chk("head_addr", bus.oOMEM_WriteAddress, sb_q[0].a);
        chk("head_data", bus.oOMEM_WriteData, sb_q[0].d);
      end
      if (bus.oOMEM_WriteEnable) begin
        if (sb_q.size() == 0) chk("unexpected_write", RW'(bus.oOMEM_WriteEnable), RW'(0));
        else void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input bit we, input bit rdy, input bit fl, input bit rst,
                       input logic [RW-1:0] a, input logic [RW-1:0] d);
    bus.iWriteEnable  = we;
    bus.iOMEM_Ready   = rdy;
    bus.iFlush        = fl;
    Reset             = rst;
    bus.iWriteAddress = a;
    bus.iWriteData    = d;
    @(posedge Clock); #1;
  endtask

  task automatic rnd(input bit we, input bit rdy, input bit fl, input bit rst);
    drive(we, rdy, fl, rst, {$urandom(), $urandom(), $urandom()},
          {$urandom(), $urandom(), $urandom()});
  endtask

  initial begin
    bus.iWriteEnable = 0; bus.iOMEM_Ready = 0; bus.iFlush = 0;
    bus.iWriteAddress = '0; bus.iWriteData = '0;
    Reset = 1;
    @(posedge Clock); #1;
    started = 1;
    drive(0, 0, 0, 1, '0, '0);

    // Three pushes with ready high: in-order writes, one-cycle latency.
    drive(1, 1, 0, 0, RW'(32'h10), {3{32'hA}});
    drive(1, 1, 0, 0, RW'(32'h11), {3{32'hB}});
    drive(1, 1, 0, 0, RW'(32'h12), {3{32'hC}});
    repeat (3) rnd(0, 1, 0, 0);

    // Nine pushes into a stalled queue: the ninth overflows.
    repeat (9) rnd(1, 0, 0, 0);
    repeat (10) rnd(0, 1, 0, 0);

    // Fill, then streaming push+pop at full occupancy across pointer wrap.
    repeat (8) rnd(1, 0, 0, 0);
    repeat (12) rnd(1, 1, 0, 0);
    repeat (10) rnd(0, 1, 0, 0);

    // Flush during a toggling-ready burst.
    rnd(1, 1, 0, 0);
    rnd(1, 0, 1, 0);
    rnd(1, 1, 0, 0);
    rnd(1, 0, 0, 0);
    repeat (4) begin rnd(0, 1, 0, 0); rnd(0, 0, 0, 0); end
    repeat (3) rnd(0, 1, 0, 0);

    // Flush on an empty idle queue.
    rnd(0, 1, 1, 0);
    repeat (4) rnd(0, 1, 0, 0);

    // Reset in the middle of a loaded queue.
    repeat (5) rnd(1, 0, 0, 0);
    rnd(0, 1, 0, 1);
    repeat (4) rnd(0, 1, 0, 0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 2000; i++)
      rnd($urandom_range(99) < 60, $urandom_range(99) < 50,
          $urandom_range(99) < 4, $urandom_range(999) < 5);

    // Drain and confirm every expected write was seen.
    repeat (20) rnd(0, 1, 0, 0);
    chk("drain_scoreboard", RW'(sb_q.size()), RW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
